// File: rtl/multicycle_datapath_regs.sv
// Multicycle MIPS datapath register block: PC, IR, MDR, A, B and ALUOut,
// plus memory-address and next-PC selection. Optional PERF_CNT_EN adds cycle/instruction counters.
module multicycle_datapath_regs #(
  parameter int                 WIDTH    = 32,
  parameter logic [WIDTH-1:0]   RESET_PC = '0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             IorD,
  input  logic             IRWrite,
  input  logic             PCWrite,
  input  logic             Branch,
  input  logic [1:0]       PCSrc,
  input  logic             zero,
  input  logic [WIDTH-1:0] alu_result,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic [WIDTH-1:0] rf_rd1,
  input  logic [WIDTH-1:0] rf_rd2,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] instr,
  output logic [WIDTH-1:0] mdr,
  output logic [WIDTH-1:0] reg_a,
  output logic [WIDTH-1:0] reg_b,
`ifdef PERF_CNT_EN
  output logic [WIDTH-1:0] alu_out,
  output logic [31:0]      cycle_cnt,
  output logic [31:0]      instr_cnt
`else
  output logic [WIDTH-1:0] alu_out
`endif
);

  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_instr;
  logic [WIDTH-1:0] r_mdr;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_alu_out;

  logic             w_pc_en;
  logic [WIDTH-1:0] w_next_pc;
  logic [WIDTH-1:0] w_jump_target;

  // Jump target is built from the IR as it stands before any same-cycle IR load.
  assign w_jump_target = {r_pc[WIDTH-1 -: 4], r_instr[25:0], 2'b00};
  assign w_pc_en       = PCWrite | (Branch & zero);

  always_comb begin
    w_next_pc = r_pc;
    case (PCSrc)
      2'b00:   w_next_pc = alu_result;
      2'b01:   w_next_pc = r_alu_out;
      2'b10:   w_next_pc = w_jump_target;
      default: w_next_pc = r_pc;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_pc      <= RESET_PC;
      r_instr   <= '0;
      r_mdr     <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_alu_out <= '0;
    end else begin
      if (w_pc_en)  r_pc    <= w_next_pc;
      if (IRWrite)  r_instr <= mem_rdata;
      r_mdr     <= mem_rdata;
      r_a       <= rf_rd1;
      r_b       <= rf_rd2;
      r_alu_out <= alu_result;
    end
  end

`ifdef PERF_CNT_EN
  logic [31:0] r_cycle_cnt;
  logic [31:0] r_instr_cnt;

  // Both counters wrap naturally at 2^32.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_cycle_cnt <= '0;
      r_instr_cnt <= '0;
    end else begin
      r_cycle_cnt <= r_cycle_cnt + 32'd1;
      if (IRWrite) r_instr_cnt <= r_instr_cnt + 32'd1;
    end
  end

  assign cycle_cnt = r_cycle_cnt;
  assign instr_cnt = r_instr_cnt;
`endif

  assign mem_addr = IorD ? r_alu_out : r_pc;
  assign pc       = r_pc;
  assign instr    = r_instr;
  assign mdr      = r_mdr;
  assign reg_a    = r_a;
  assign reg_b    = r_b;
  assign alu_out  = r_alu_out;

endmodule

// File: tb/tb_multicycle_datapath_regs.sv
// Directed bench for multicycle_datapath_regs; counter checks run when PERF_CNT_EN is defined.
module tb_multicycle_datapath_regs;

  localparam int          WIDTH    = 32;
  localparam logic [31:0] RESET_PC = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        clr;
  logic        IorD, IRWrite, PCWrite, Branch, zero;
  logic [1:0]  PCSrc;
  logic [31:0] alu_result, mem_rdata, rf_rd1, rf_rd2;
  logic [31:0] pc, mem_addr, instr, mdr, reg_a, reg_b, alu_out;
`ifdef PERF_CNT_EN
  logic [31:0] cycle_cnt, instr_cnt;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  multicycle_datapath_regs #(.WIDTH(WIDTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .clr(clr), .IorD(IorD), .IRWrite(IRWrite), .PCWrite(PCWrite),
    .Branch(Branch), .PCSrc(PCSrc), .zero(zero), .alu_result(alu_result),
    .mem_rdata(mem_rdata), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2), .pc(pc),
    .mem_addr(mem_addr), .instr(instr), .mdr(mdr), .reg_a(reg_a), .reg_b(reg_b),
`ifdef PERF_CNT_EN
    .alu_out(alu_out), .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
`else
    .alu_out(alu_out)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1ns past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clr = 1'b0; IorD = 0; IRWrite = 0; PCWrite = 0; Branch = 0; zero = 0;
    PCSrc = 2'b00; alu_result = '0; mem_rdata = '0; rf_rd1 = '0; rf_rd2 = '0;
    #12;
    chk("rst_pc", pc, 32'h0040_0000);
    chk("rst_instr", instr, 32'h0);
    chk("rst_alu_out", alu_out, 32'h0);

    // First edge after release performs a normal update.
    clr = 1'b1; alu_result = 32'h0040_0004; PCWrite = 1; PCSrc = 2'b00;
    tick();
    chk("release_pc", pc, 32'h0040_0004);
    chk("release_alu_out", alu_out, 32'h0040_0004);

    // Fetch
    alu_result = 32'h0000_0010;
    tick();
    chk("pc_to_10", pc, 32'h0000_0010);
    PCWrite = 0; IorD = 0; IRWrite = 1; mem_rdata = 32'h8C22_0004;
    #1;
    chk("fetch_addr", mem_addr, 32'h0000_0010);
    tick();
    chk("fetch_instr", instr, 32'h8C22_0004);
    chk("fetch_mdr", mdr, 32'h8C22_0004);
    IRWrite = 0; mem_rdata = 32'hDEAD_BEEF;
    tick();
    chk("ir_hold", instr, 32'h8C22_0004);
    chk("mdr_follow", mdr, 32'hDEAD_BEEF);

    // Branch
    alu_result = 32'h0000_0100;
    tick();
    Branch = 1; PCSrc = 2'b01; zero = 0;
    tick();
    chk("br_not_taken", pc, 32'h0000_0010);
    zero = 1;
    tick();
    chk("br_taken", pc, 32'h0000_0100);
    Branch = 0; zero = 0; PCWrite = 1; PCSrc = 2'b11;
    tick();
    chk("pcsrc11_hold", pc, 32'h0000_0100);
    PCSrc = 2'b00; alu_result = 32'h0000_0200; Branch = 1; zero = 0;
    tick();
    chk("pcw_and_br", pc, 32'h0000_0200);

    // Jump, including same-cycle IR load
    Branch = 0; alu_result = 32'hA000_0000; IRWrite = 1; mem_rdata = 32'h0800_0040;
    tick();
    chk("jmp_setup_pc", pc, 32'hA000_0000);
    chk("jmp_setup_ir", instr, 32'h0800_0040);
    PCSrc = 2'b10; mem_rdata = 32'h0BFF_FFFF;
    tick();
    chk("jump_pc", pc, 32'hA000_0100);
    chk("jump_ir_new", instr, 32'h0BFF_FFFF);

    // Load address and pipeline registers
    IRWrite = 0; PCWrite = 0; PCSrc = 2'b00; IorD = 1; alu_result = 32'h0000_2000;
    tick();
    chk("load_addr", mem_addr, 32'h0000_2000);
    rf_rd1 = 32'd5; rf_rd2 = 32'd7; alu_result = 32'd12; mem_rdata = 32'h0000_1234;
    tick();
    chk("reg_a", reg_a, 32'd5);
    chk("reg_b", reg_b, 32'd7);
    chk("alu_out", alu_out, 32'd12);
    chk("mdr", mdr, 32'h0000_1234);
    IorD = 0;
    #1;
    chk("addr_back_to_pc", mem_addr, 32'hA000_0100);

    // Asynchronous clear mid-cycle
    tick();
    #2;
    clr = 1'b0;
    #1;
    chk("async_pc", pc, 32'h0040_0000);
    chk("async_instr", instr, 32'h0);
    chk("async_mdr", mdr, 32'h0);
    chk("async_reg_a", reg_a, 32'h0);
    chk("async_reg_b", reg_b, 32'h0);
    chk("async_alu_out", alu_out, 32'h0);
    PCWrite = 1; alu_result = 32'h0000_0044;
    tick();
    chk("clr_held_pc", pc, 32'h0040_0000);
    clr = 1'b1;
    tick();
    chk("post_clr_pc", pc, 32'h0000_0044);

`ifdef PERF_CNT_EN
    PCWrite = 0;
    clr = 1'b0;
    #1;
    chk("cnt_rst_cycle", cycle_cnt, 32'd0);
    chk("cnt_rst_instr", instr_cnt, 32'd0);
    clr = 1'b1;
    for (int i = 0; i < 10; i++) begin
      IRWrite = (i == 2 || i == 5 || i == 8);
      tick();
    end
    IRWrite = 0;
    chk("cycle_cnt_10", cycle_cnt, 32'd10);
    chk("instr_cnt_3", instr_cnt, 32'd3);
    clr = 1'b0;
    #1;
    chk("cycle_cnt_clr", cycle_cnt, 32'd0);
    chk("instr_cnt_clr", instr_cnt, 32'd0);
    clr = 1'b1;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_datapath_regs.md
Name: multicycle_datapath_regs

Overview:
- Architectural and inter-cycle register block of the multicycle MIPS datapath: PC, IR, MDR, A, B and ALUOut.
- Sits directly downstream of the main control FSM and consumes its IorD, IRWrite, PCWrite, Branch and PCSrc strobes.
- Drives the memory address and the next-PC selection back into the datapath.
- Holds every value that must survive from one FSM state to the next.

Parameters:
- WIDTH, 32, datapath and address width in bits; must be 32 for MIPS jump-target formation.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  input  1  system clock; all registers update on the rising edge.
- clr  input  1  asynchronous, active-low reset (clr=0 resets immediately, independent of clk).
- IorD  input  1  memory address select: 0 selects PC, 1 selects ALUOut.
- IRWrite  input  1  load IR from mem_rdata.
- PCWrite  input  1  unconditional PC load.
- Branch  input  1  conditional PC load when zero=1.
- PCSrc  input  2  next-PC select: 00 alu_result, 01 alu_out, 10 jump target, 11 hold current PC.
- zero  input  1  ALU zero flag from the current cycle.
- alu_result  input  WIDTH  combinational ALU result.
- mem_rdata  input  WIDTH  memory read data.
- rf_rd1  input  WIDTH  register-file read port 1.
- rf_rd2  input  WIDTH  register-file read port 2.
- pc  output  WIDTH  current program counter.
- mem_addr  output  WIDTH  memory address.
- instr  output  WIDTH  instruction register.
- mdr  output  WIDTH  memory data register.
- reg_a  output  WIDTH  A register.
- reg_b  output  WIDTH  B register; also used as memory write data.
- alu_out  output  WIDTH  registered ALU result.

Behaviour:
- Reset (clr=0, asynchronous): pc=RESET_PC; instr, mdr, reg_a, reg_b, alu_out all 0. Reset asserted mid-instruction discards all partial state; the first rising edge after clr returns high performs a normal update.
- PC enable: pc_en = PCWrite | (Branch & zero). When pc_en=1, pc loads next_pc on the edge; otherwise pc holds.
- next_pc by PCSrc:
  - 00: alu_result
  - 01: alu_out
  - 10: {pc[31:28], instr[25:0], 2'b00}
  - 11: pc
- Simultaneous PCWrite=1 and Branch=1: the PC loads regardless of zero.
- IR loads mem_rdata only when IRWrite=1; otherwise it holds. With IRWrite=1 and PCWrite=1 in the same cycle, IR captures the word at the old PC and the PC updates.
- Jump-target formation uses the IR value before any same-cycle IR load.
- mdr, reg_a, reg_b and alu_out load unconditionally every cycle. Each has exactly 1-cycle latency from its input.
- mem_addr is combinational: IorD ? alu_out : pc. It has no registered latency and must be glitch-free only at the clock edge.
- No arithmetic in this block except concatenation. PC increment is done by the ALU; no wrap checks here. A PC of 32'hFFFF_FFFC + 4 from the ALU wraps to 0 naturally.
- Unknown or X control inputs are not filtered; the controller guarantees defined strobes after reset.

Optional Feature:
- Macro: PERF_CNT_EN.
- When defined, two extra outputs are added:
  - cycle_cnt [31:0]: increments every cycle while clr=1.
  - instr_cnt [31:0]: increments on every cycle with IRWrite=1.
- Both counters reset to 0 on clr=0 and wrap from 32'hFFFF_FFFF to 0.
- When not defined, the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Reset and async clear:
  - Drive clr=0 mid-cycle with RESET_PC=32'h0040_0000 -> pc=32'h0040_0000 and all other registers 0 immediately, without waiting for a clock edge.
  - Release clr, then alu_result=32'h0040_0004, PCWrite=1, PCSrc=00 -> pc=32'h0040_0004 after 1 edge.
- Fetch:
  - pc=32'h0000_0010, IorD=0, IRWrite=1, mem_rdata=32'h8C22_0004 -> mem_addr=32'h0000_0010 before the edge; instr=32'h8C22_0004 after the edge.
  - Following cycle with IRWrite=0 and a new mem_rdata -> instr unchanged.
- Branch:
  - Branch=1, PCSrc=01, alu_out=32'h0000_0100, zero=0 -> pc holds.
  - Same with zero=1 -> pc=32'h0000_0100.
- Jump:
  - pc=32'hA000_0000, instr=32'h0800_0040, PCSrc=10, PCWrite=1 -> pc=32'hA000_0100.
- Load address and pipeline registers:
  - IorD=1, alu_out=32'h0000_2000 -> mem_addr=32'h0000_2000.
  - rf_rd1=5, rf_rd2=7, alu_result=12 -> reg_a=5, reg_b=7, alu_out=12 one edge later.
- PERF_CNT_EN build:
  - 10 cycles after reset with IRWrite pulsed 3 times -> cycle_cnt=10, instr_cnt=3.
  - clr=0 -> both counters 0.
